// File: rtl/change_dispenser.sv
// change_dispenser: pays an exchange amount as 50/10/5/1 coins, greedily,
// from per-denomination inventory over a valid/ack hopper handshake.
module change_dispenser #(
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 8,
   parameter int INIT_50 = 8,
   parameter int INIT_10 = 16,
   parameter int INIT_5  = 16,
   parameter int INIT_1  = 32
) (
   input  logic             CLOCK,
   input  logic             CLEAR,
   input  logic [1:0]       condition,
   input  logic [WIDTH-1:0] exchange_coin,
   input  logic             refill,
   input  logic             coin_ack,
   output logic             coin_valid,
   output logic [WIDTH-1:0] coin_value,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] shortfall,
   output logic [CNT_W-1:0] cnt_50,
   output logic [CNT_W-1:0] cnt_10,
   output logic [CNT_W-1:0] cnt_5,
   output logic [CNT_W-1:0] cnt_1
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SELECT,
      S_ISSUE,
      S_DONE
   } state_t;

   localparam logic [WIDTH-1:0] D50 = WIDTH'(50);
   localparam logic [WIDTH-1:0] D10 = WIDTH'(10);
   localparam logic [WIDTH-1:0] D5  = WIDTH'(5);
   localparam logic [WIDTH-1:0] D1  = WIDTH'(1);

   localparam logic [CNT_W-1:0] I50 = CNT_W'(INIT_50);
   localparam logic [CNT_W-1:0] I10 = CNT_W'(INIT_10);
   localparam logic [CNT_W-1:0] I5  = CNT_W'(INIT_5);
   localparam logic [CNT_W-1:0] I1  = CNT_W'(INIT_1);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] remaining, remaining_nx;
   logic [1:0]       prev_cond;
   logic             valid_nx;
   logic [WIDTH-1:0] value_nx;
   logic             done_nx;
   logic [WIDTH-1:0] short_nx;
   logic [CNT_W-1:0] c50_nx, c10_nx, c5_nx, c1_nx;

   logic trigger;
   logic ok50, ok10, ok5, ok1;

   assign trigger = (condition == 2'b10) && (prev_cond != 2'b10);

   // A denomination qualifies only if it fits and is in stock
   assign ok50 = (remaining >= D50) && (cnt_50 != '0);
   assign ok10 = (remaining >= D10) && (cnt_10 != '0);
   assign ok5  = (remaining >= D5)  && (cnt_5  != '0);
   assign ok1  = (remaining >= D1)  && (cnt_1  != '0);

   assign busy = (state != S_IDLE);

   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      valid_nx     = coin_valid;
      value_nx     = coin_value;
      done_nx      = 1'b0;
      short_nx     = shortfall;
      c50_nx       = cnt_50;
      c10_nx       = cnt_10;
      c5_nx        = cnt_5;
      c1_nx        = cnt_1;

      unique case (state)
         S_IDLE: begin
            if (refill) begin
               c50_nx = I50;
               c10_nx = I10;
               c5_nx  = I5;
               c1_nx  = I1;
            end
            if (trigger) begin
               remaining_nx = exchange_coin;
               short_nx     = '0;
               state_nx     = S_SELECT;
            end
         end

         S_SELECT: begin
            valid_nx = 1'b1;
            state_nx = S_ISSUE;
            if (ok50) begin
               value_nx = D50;
            end else if (ok10) begin
               value_nx = D10;
            end else if (ok5) begin
               value_nx = D5;
            end else if (ok1) begin
               value_nx = D1;
            end else begin
               valid_nx = 1'b0;
               value_nx = '0;
               done_nx  = 1'b1;
               short_nx = remaining;
               state_nx = S_DONE;
            end
         end

         S_ISSUE: begin
            if (coin_ack) begin
               remaining_nx = remaining - coin_value;
               valid_nx     = 1'b0;
               value_nx     = '0;
               state_nx     = S_SELECT;
               unique case (1'b1)
                  (coin_value == D50): c50_nx = cnt_50 - ONE;
                  (coin_value == D10): c10_nx = cnt_10 - ONE;
                  (coin_value == D5):  c5_nx  = cnt_5  - ONE;
                  (coin_value == D1):  c1_nx  = cnt_1  - ONE;
                  default: ;
               endcase
            end
         end

         S_DONE: begin
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (CLEAR) begin
         state      <= S_IDLE;
         remaining  <= '0;
         prev_cond  <= 2'b00;
         coin_valid <= 1'b0;
         coin_value <= '0;
         done       <= 1'b0;
         shortfall  <= '0;
         cnt_50     <= I50;
         cnt_10     <= I10;
         cnt_5      <= I5;
         cnt_1      <= I1;
      end else begin
         state      <= state_nx;
         remaining  <= remaining_nx;
         prev_cond  <= condition;
         coin_valid <= valid_nx;
         coin_value <= value_nx;
         done       <= done_nx;
         shortfall  <= short_nx;
         cnt_50     <= c50_nx;
         cnt_10     <= c10_nx;
         cnt_5      <= c5_nx;
         cnt_1      <= c1_nx;
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: three dispensers with different stock, driven from a
// vector table plus hand sequences; coins are checked against a queue.
module tb_change_dispenser;

   localparam int W  = 32;
   localparam int CW = 8;

   typedef struct packed {
      int              inst;
      int              amt;
      int              dly;
      int              rf;
      int              sf;
      logic [0:3][7:0] pay;
      logic [0:3][7:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          clr;
   logic [1:0]    cond [3];
   logic [W-1:0]  exch [3];
   logic          refill [3];
   logic          ack [3];
   logic          cv [3];
   logic [W-1:0]  cval [3];
   logic          busy [3];
   logic          done [3];
   logic [W-1:0]  sf [3];
   logic [CW-1:0] c50 [3];
   logic [CW-1:0] c10 [3];
   logic [CW-1:0] c5 [3];
   logic [CW-1:0] c1 [3];

   int ack_dly [3];
   int wcnt [3];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int expq [$];
   int mon_g = -1;
   int first_cv = -1;
   int last_ack = -1;
   int ncoins = 0;
   int den [4] = '{50, 10, 5, 1};
   vec_t tbl [11];

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int I10 = (g == 1) ? 1 : 16;
      localparam int I1  = (g == 2) ? 0 : 32;
      change_dispenser #(
         .WIDTH(W), .CNT_W(CW), .INIT_50(8),
         .INIT_10(I10), .INIT_5(16), .INIT_1(I1)
      ) dut (
         .CLOCK(clk),
         .CLEAR(clr),
         .condition(cond[g]),
         .exchange_coin(exch[g]),
         .refill(refill[g]),
         .coin_ack(ack[g]),
         .coin_valid(cv[g]),
         .coin_value(cval[g]),
         .busy(busy[g]),
         .done(done[g]),
         .shortfall(sf[g]),
         .cnt_50(c50[g]),
         .cnt_10(c10[g]),
         .cnt_5(c5[g]),
         .cnt_1(c1[g])
      );
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Hopper model: acks a coin once it has been shown for ack_dly cycles
   always @(posedge clk) begin
      #1;
      for (int g = 0; g < 3; g++) begin
         if (cv[g]) wcnt[g] = wcnt[g] + 1;
         else wcnt[g] = 0;
         ack[g] = cv[g] && (wcnt[g] > ack_dly[g]);
      end
   end

   task automatic chk(string nm, longint got, longint exp_v);
      checks++;
      if (got != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (mon_g >= 0 && cv[mon_g]) begin
         if (first_cv < 0) first_cv = cyc;
         if (expq.size() == 0) begin
            chk("coin_extra", cval[mon_g], 0);
         end else begin
            chk("coin_value", cval[mon_g], expq[0]);
         end
         if (ack[mon_g]) begin
            if (expq.size() != 0) void'(expq.pop_front());
            last_ack = cyc;
            ncoins++;
         end
      end
   end

   function automatic int init_of(int g, int d);
      case (d)
         0: return 8;
         1: return (g == 1) ? 1 : 16;
         2: return 16;
         default: return (g == 2) ? 0 : 32;
      endcase
   endfunction

   function automatic vec_t mk(int inst, int amt, int dly, int rf, int sfx,
                               logic [0:3][7:0] pay, logic [0:3][7:0] cnt);
      vec_t v;
      v.inst = inst;
      v.amt  = amt;
      v.dly  = dly;
      v.rf   = rf;
      v.sf   = sfx;
      v.pay  = pay;
      v.cnt  = cnt;
      return v;
   endfunction

   task automatic chk_cnt(int g, logic [0:3][7:0] e);
      chk("cnt_50", c50[g], e[0]);
      chk("cnt_10", c10[g], e[1]);
      chk("cnt_5", c5[g], e[2]);
      chk("cnt_1", c1[g], e[3]);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 clr = 1'b1;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      for (int g = 0; g < 3; g++) begin
         chk("rst_valid", cv[g], 0);
         chk("rst_value", cval[g], 0);
         chk("rst_busy", busy[g], 0);
         chk("rst_done", done[g], 0);
         chk("rst_short", sf[g], 0);
         chk_cnt(g, {8'(init_of(g, 0)), 8'(init_of(g, 1)),
                     8'(init_of(g, 2)), 8'(init_of(g, 3))});
      end
   endtask

   task automatic run_vec(vec_t v);
      int g = v.inst;
      int tc;
      int total = 0;
      bit got = 0;
      expq.delete();
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < int'(v.pay[d]); k++) expq.push_back(den[d]);
         total += int'(v.pay[d]);
      end
      ack_dly[g] = v.dly;
      first_cv = -1;
      last_ack = -1;
      mon_g = g;
      @(posedge clk);
      #1;
      cond[g] = 2'b10;
      exch[g] = v.amt;
      refill[g] = (v.rf != 0);
      tc = cyc;
      @(posedge clk);
      #1 refill[g] = 1'b0;
      for (int i = 0; i < 600 && !got; i++) begin
         @(negedge clk);
         if (done[g]) got = 1;
      end
      chk("done_seen", got, 1);
      if (got) begin
         if (total == 0) begin
            chk("done_latency", cyc - tc, 2);
         end else begin
            chk("first_coin_lat", first_cv - tc, 2);
            chk("ack_to_done", cyc - last_ack, 2);
         end
         chk("shortfall", sf[g], v.sf);
         chk("coins_left", expq.size(), 0);
         chk_cnt(g, v.cnt);
         @(negedge clk);
         chk("done_pulse", done[g], 0);
         chk("busy_after", busy[g], 0);
      end
      cond[g] = 2'b00;
      mon_g = -1;
      expq.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int ndone;
      bit seen;
      clr = 1'b1;
      for (int g = 0; g < 3; g++) begin
         cond[g] = 2'b00;
         exch[g] = '0;
         refill[g] = 1'b0;
         ack_dly[g] = 0;
      end

      tbl[0]  = mk(0, 66, 0, 0, 0, {8'd1, 8'd1, 8'd1, 8'd1},
                   {8'd7, 8'd15, 8'd15, 8'd31});
      tbl[1]  = mk(0, 27, 3, 0, 0, {8'd0, 8'd2, 8'd1, 8'd2},
                   {8'd7, 8'd13, 8'd14, 8'd29});
      tbl[2]  = mk(0, 123, 0, 0, 0, {8'd2, 8'd2, 8'd0, 8'd3},
                   {8'd5, 8'd11, 8'd14, 8'd26});
      tbl[3]  = mk(1, 30, 0, 0, 0, {8'd0, 8'd1, 8'd4, 8'd0},
                   {8'd8, 8'd0, 8'd12, 8'd32});
      tbl[4]  = mk(1, 9, 0, 0, 0, {8'd0, 8'd0, 8'd1, 8'd4},
                   {8'd8, 8'd0, 8'd11, 8'd28});
      tbl[5]  = mk(1, 30, 0, 1, 0, {8'd0, 8'd1, 8'd4, 8'd0},
                   {8'd8, 8'd0, 8'd12, 8'd32});
      tbl[6]  = mk(2, 3, 0, 0, 3, {8'd0, 8'd0, 8'd0, 8'd0},
                   {8'd8, 8'd16, 8'd16, 8'd0});
      tbl[7]  = mk(2, 0, 0, 0, 0, {8'd0, 8'd0, 8'd0, 8'd0},
                   {8'd8, 8'd16, 8'd16, 8'd0});
      tbl[8]  = mk(2, 17, 1, 0, 2, {8'd0, 8'd1, 8'd1, 8'd0},
                   {8'd8, 8'd15, 8'd15, 8'd0});
      tbl[9]  = mk(0, 500, 0, 1, 0, {8'd8, 8'd10, 8'd0, 8'd0},
                   {8'd0, 8'd6, 8'd16, 8'd32});
      tbl[10] = mk(0, 60, 0, 0, 0, {8'd0, 8'd6, 8'd0, 8'd0},
                   {8'd0, 8'd0, 8'd16, 8'd32});

      do_reset();
      for (int i = 0; i < 11; i++) run_vec(tbl[i]);

      // refill honoured in IDLE
      @(posedge clk);
      #1 refill[0] = 1'b1;
      @(posedge clk);
      #1 refill[0] = 1'b0;
      chk_cnt(0, {8'd8, 8'd16, 8'd16, 8'd32});

      // retrigger and refill while busy are ignored
      do_reset();
      expq.delete();
      expq.push_back(50);
      expq.push_back(10);
      expq.push_back(5);
      expq.push_back(1);
      ack_dly[0] = 0;
      ncoins = 0;
      first_cv = -1;
      mon_g = 0;
      @(posedge clk);
      #1;
      cond[0] = 2'b10;
      exch[0] = 66;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      cond[0] = 2'b00;
      refill[0] = 1'b1;
      @(posedge clk);
      #1;
      cond[0] = 2'b10;
      exch[0] = 5;
      refill[0] = 1'b0;
      @(posedge clk);
      #1 refill[0] = 1'b1;
      @(posedge clk);
      #1 refill[0] = 1'b0;
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done[0]) ndone++;
      end
      chk("busy_done_count", ndone, 1);
      chk("busy_coin_count", ncoins, 4);
      chk("busy_coins_left", expq.size(), 0);
      chk("busy_idle", busy[0], 0);
      chk_cnt(0, {8'd7, 8'd15, 8'd15, 8'd31});
      cond[0] = 2'b00;
      mon_g = -1;

      // reset while a coin waits for ack
      expq.delete();
      expq.push_back(10);
      ack_dly[0] = 1000;
      mon_g = 0;
      @(posedge clk);
      #1;
      cond[0] = 2'b10;
      exch[0] = 10;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (cv[0]) seen = 1;
      end
      chk("issue_seen", seen, 1);
      repeat (3) @(negedge clk);
      chk("issue_hold", cv[0], 1);
      @(posedge clk);
      #1 clr = 1'b1;
      mon_g = -1;
      @(posedge clk);
      #1 clr = 1'b0;
      chk("mid_rst_valid", cv[0], 0);
      chk("mid_rst_value", cval[0], 0);
      chk("mid_rst_busy", busy[0], 0);
      chk("mid_rst_short", sf[0], 0);
      chk_cnt(0, {8'd8, 8'd16, 8'd16, 8'd32});
      cond[0] = 2'b00;
      expq.delete();
      run_vec(tbl[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Return-change dispenser that sits at the far end of the vending FSM's exchange interface. It consumes the FSM's `condition` and `exchange_coin` outputs. On each exchange event it pays out the amount one physical coin at a time to a coin hopper, using a valid/ack handshake. It picks coins greedily from per-denomination inventory counters and reports any amount it could not pay.

Parameters:
- WIDTH, 32, width of `exchange_coin`, `coin_value`, `shortfall`
- CNT_W, 8, width of each inventory counter
- INIT_50, 8, 50-dollar coins loaded at reset/refill
- INIT_10, 16, 10-dollar coins loaded at reset/refill
- INIT_5, 16, 5-dollar coins loaded at reset/refill
- INIT_1, 32, 1-dollar coins loaded at reset/refill

Ports:
- CLOCK  in  1  single system clock, rising edge
- CLEAR  in  1  synchronous, active-high reset
- condition  in  2  from vending FSM: 00 info, 01 out, 10 exchange
- exchange_coin  in  WIDTH  change amount; valid while condition==2'b10
- refill  in  1  reload all inventory counters to INIT_*; honoured only in IDLE
- coin_ack  in  1  hopper has taken the presented coin
- coin_valid  out  1  a coin is being presented
- coin_value  out  WIDTH  denomination presented (50/10/5/1); 0 when coin_valid=0
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a payout finishes
- shortfall  out  WIDTH  unpaid remainder of the last payout; held until the next trigger
- cnt_50, cnt_10, cnt_5, cnt_1  out  CNT_W each  current inventory

Behaviour:
- Reset (CLEAR=1 at a rising edge), which has priority over everything including mid-payout:
  - state=IDLE
  - coin_valid=0, coin_value=0, busy=0, done=0, shortfall=0
  - cnt_*=INIT_*
  - remaining=0, prev_cond=2'b00
- Trigger: condition==2'b10 && prev_cond!=2'b10 (rising edge into exchange). prev_cond is registered every cycle, in all states.
- Only a trigger sampled in IDLE is accepted. Triggers while busy are dropped, not queued.
- States:
  - IDLE:
    - On trigger: remaining<=exchange_coin, shortfall<=0, go to SELECT.
    - If refill=1: cnt_*<=INIT_*. Refill and trigger in the same cycle are both applied; SELECT sees the refilled counts.
  - SELECT (coin_valid=0): pick the largest d in {50,10,5,1} with d<=remaining and cnt_d>0.
    - If a d exists: coin_value<=d, coin_valid<=1, go to ISSUE.
    - If remaining==0 or no d qualifies: go to DONE.
  - ISSUE: coin_valid=1 and coin_value are held stable until coin_ack=1 is sampled.
    - On that edge: remaining<=remaining-d, cnt_d<=cnt_d-1, coin_valid<=0, coin_value<=0, go to SELECT.
    - coin_ack outside ISSUE is ignored.
  - DONE: done=1 for exactly one cycle, shortfall=remaining, go to IDLE.
- Timing:
  - Trigger to first coin_valid: 2 cycles.
  - With coin_ack tied high: one coin every 2 cycles.
  - Last ack to done: 2 cycles.
- Inventory:
  - A counter at 0 is skipped and the search falls through to smaller denominations. This is greedy, with no backtracking.
  - Counters never underflow.
  - refill outside IDLE is ignored.
- exchange_coin==0 at trigger: IDLE→SELECT→DONE, no coins, shortfall=0.
- Arithmetic is unsigned WIDTH-bit. remaining never goes negative, because d<=remaining is checked first.

Test Plan:
1. Basic payout: defaults, coin_ack=1, trigger with exchange_coin=66 → coins 50,10,5,1 in order; done pulse; shortfall=0; cnt_50=7, cnt_10=15, cnt_5=15, cnt_1=31.
2. Repeated denominations and handshake: exchange_coin=27, coin_ack asserted 3 cycles after each coin_valid → coins 10,10,5,1,1. coin_value is stable while waiting; done ~2 cycles after the last ack.
3. Inventory fallback: INIT_10=1, exchange_coin=30 → coins 10,5,5,5,5; cnt_10=0; shortfall=0.
4. Shortfall: INIT_1=0, exchange_coin=3 → no coin_valid; done after 2 cycles; shortfall=3. A second trigger with exchange_coin=0 → shortfall=0.
5. Retrigger and refill while busy: during payout of 66, toggle condition 10→00→10 and pulse refill → ignored. Exactly 4 coins paid, and counts show no refill.
6. Reset mid-ISSUE: assert CLEAR while coin_valid=1 awaiting ack → next cycle coin_valid=0, busy=0, cnt_*=INIT_*, shortfall=0. A new trigger works normally.
